// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional macro MULT_DIV_FAST_MULT_EN: multiplies complete in the start cycle via a 64-bit product.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        write_hi,
  input  logic        write_lo,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] mag_a, mag_b, a_raw;
  logic [63:0] acc;
  logic        neg_q, neg_r, is_div;

  function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] x, input logic n);
    return n ? -x : x;
  endfunction

  // Operand magnitudes and sign flags; op[0]=0 selects the signed variants.
  logic        sgn_a, sgn_b;
  logic [31:0] start_mag_a, start_mag_b;
  assign sgn_a       = ~op[0] & a[31];
  assign sgn_b       = ~op[0] & b[31];
  assign start_mag_a = cond_neg32(a, sgn_a);
  assign start_mag_b = cond_neg32(b, sgn_b);

  // Shift-add step: low half holds the remaining multiplier bits.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag_a : 32'd0)};
  assign mul_next = {mul_sum, acc[31:1]};

  // Restoring step: {remainder, dividend/quotient} shifted left, trial subtract.
  logic [64:0] div_sh;
  logic [32:0] div_trial;
  logic [63:0] div_next;
  assign div_sh    = {acc, 1'b0};
  assign div_trial = div_sh[64:32] - {1'b0, mag_b};
  assign div_next  = div_trial[32] ? div_sh[63:0]
                                   : {div_trial[31:0], div_sh[31:1], 1'b1};

`ifdef MULT_DIV_FAST_MULT_EN
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= 5'd31;
`ifdef MULT_DIV_FAST_MULT_EN
            if (op[1]) begin
              state <= DIV;
            end else begin
              {hi, lo} <= op[0] ? prod_u : prod_s;
              done     <= 1'b1;
            end
`else
            state <= op[1] ? DIV : MUL;
`endif
          end else begin
            if (write_hi) hi <= data_in;
            if (write_lo) lo <= data_in;
          end
        end
        MUL, DIV: begin
          if (cnt == 5'd0) state <= FIX;
          else             cnt   <= cnt - 5'd1;
        end
        default: begin
          // Sign correction and divide-by-zero result.
          if (is_div) begin
            if (mag_b == 32'd0) begin
              hi <= a_raw;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= cond_neg32(acc[63:32], neg_r);
              lo <= cond_neg32(acc[31:0], neg_q);
            end
          end else begin
            {hi, lo} <= cond_neg64(acc, neg_q);
          end
          done  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath registers carry no reset; they are always reloaded at start.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          mag_a  <= start_mag_a;
          mag_b  <= start_mag_b;
          a_raw  <= a;
          neg_q  <= sgn_a ^ sgn_b;
          neg_r  <= sgn_a;
          is_div <= op[1];
          acc    <= op[1] ? {32'd0, start_mag_a} : {32'd0, start_mag_b};
        end
      end
      MUL:     acc <= mul_next;
      DIV:     acc <= div_next;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issued ops push expected HI/LO, a monitor checks on done.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, write_hi, write_lo;
  logic [1:0]  op;
  logic [31:0] a, b, data_in;
  logic        busy, done;
  logic [31:0] hi, lo;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .write_hi(write_hi), .write_lo(write_lo), .data_in(data_in),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

`ifdef MULT_DIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    int          blen;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   bcnt   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk = n_chk + 1;
    if (act === expv) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference from the arithmetic definitions of the instructions.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: p = 64'(sx * sy);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Called at a negedge with the unit ready to accept start.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit track);
    exp_t        e;
    logic [63:0] r;
    int          lat;
    op = o; a = x; b = y; start = 1'b1;
    if (track) begin
      r      = ref_op(o, x, y);
      lat    = (FAST && !o[1]) ? 1 : 34;
      e.hi   = r[63:32];
      e.lo   = r[31:0];
      e.due  = cyc + lat;
      e.blen = (lat == 1) ? 0 : 33;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a  = $urandom;
    b  = $urandom;
    op = 2'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    chk("wait_idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("wait_done_timeout", 64'(done), 64'd1);
  endtask

  // Monitor: each done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt = bcnt + 1;
      if (done) begin
        if (sbq.size() == 0) begin
          n_chk = n_chk + 1;
          $display("FAIL unexpected_done: done=1 with no operation outstanding (t=%0t)", $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("result_hi", 64'(hi), 64'(mon_e.hi));
          chk("result_lo", 64'(lo), 64'(mon_e.lo));
          chk("done_cycle", 64'(cyc), 64'(mon_e.due));
          chk("busy_cycles", 64'(bcnt), 64'(mon_e.blen));
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    int dn;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    op = 2'd0; a = 32'd0; b = 32'd0; data_in = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_quiet();

    // Abort mid-operation.
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FAST);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);

    wait_idle(); issue(2'd0, -32'sd3, 32'd7, 1'b1);
    wait_idle(); issue(2'd2, -32'sd7, 32'd2, 1'b1);
    wait_idle(); issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle(); issue(2'd3, 32'd100, 32'd0, 1'b1);
    wait_idle(); issue(2'd2, -32'sd5, 32'd0, 1'b1);
    wait_quiet();

    // MTHI / MTLO in IDLE.
    data_in = 32'h1234; write_hi = 1'b1;
    @(negedge clk);
    write_hi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_no_done", 64'(done), 64'd0);
    data_in = 32'hCAFE_F00D; write_hi = 1'b1; write_lo = 1'b1;
    @(negedge clk);
    write_hi = 1'b0; write_lo = 1'b0;
    chk("both_hi", 64'(hi), 64'hCAFE_F00D);
    chk("both_lo", 64'(lo), 64'hCAFE_F00D);

    // Writes and a second start while a DIV is in flight are ignored.
    issue(2'd2, 32'd1000, -32'sd7, 1'b1);
    data_in = 32'hDEAD_BEEF; write_lo = 1'b1; write_hi = 1'b1;
    op = 2'd1; a = 32'd5; b = 32'd5; start = 1'b1;
    repeat (5) @(negedge clk);
    write_lo = 1'b0; write_hi = 1'b0; start = 1'b0;
    wait_quiet();

    // start together with write_lo: the write is dropped.
    data_in = 32'h5555_5555; write_lo = 1'b1;
    @(negedge clk);
    write_lo = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h5555_5555);
    data_in = 32'hAAAA_AAAA; write_lo = 1'b1;
    issue(2'd3, 32'd9, 32'd4, 1'b1);
    write_lo = 1'b0;
    chk("start_drops_mtlo", 64'(lo), 64'h5555_5555);
    wait_quiet();

    // Back-to-back issue in the done cycle.
    issue(2'd0, 32'd123, -32'sd45, 1'b1);
    wait_done();
    issue(2'd3, 32'd9, 32'd4, 1'b1);
    wait_quiet();

    wait_idle(); issue(2'd1, 32'd6, 32'd7, 1'b1);
    wait_quiet();

    repeat (25) begin
      wait_idle();
      ro = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       begin ra = $urandom; rb = $urandom; end
        1:       begin ra = $urandom; rb = 32'($urandom_range(0, 20)); end
        2:       begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
        default: begin ra = -32'($urandom_range(1, 1000)); rb = -32'($urandom_range(0, 50)); end
      endcase
      issue(ro, ra, rb, 1'b1);
    end
    wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
